line_mem_responder: RTL and testbench



---
 rtl/line_mem_responder.sv | 130 +++++++++++++
 tb/tb_line_mem_responder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_mem_responder.sv
// line_mem_responder
// Line-wide (64-bit, four 16-bit words) backing memory for the I/D cache
// controller. Accepts one re/we request at a time, holds it for a fixed
// number of clock edges, then commits the write or returns the read line
// and pulses rdy for one cycle.
//
// Ports:
//   clk     - clock
//   rst_n   - asynchronous active-low reset (control state only, not the array)
//   addr    - line address of the request
//   re, we  - read / write request; we wins when both are high
//   wdata   - write line, word0 = bits [15:0]
//   rd_data - registered read line, valid in the rdy cycle, held until next read
//   rdy     - one-cycle completion pulse (state DONE)
//   busy    - high while a request is in flight (BUSY or DONE)
module line_mem_responder #(
    parameter int ADDR_W    = 14,
    parameter int LATENCY   = 4,
    parameter     INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              re,
    input  logic              we,
    input  logic [63:0]       wdata,
    output logic [63:0]       rd_data,
    output logic              rdy,
    output logic              busy
);

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
    // With a single-edge latency the access completes on the sampling edge
    // itself, so the request goes straight to DONE using the live inputs.
    localparam bit         DIRECT   = (LATENCY == 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    logic [63:0] mem [DEPTH];

    state_t            state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [63:0]       wdata_reg;
    logic              write_reg;

    logic              start;
    logic              commit;
    logic              commit_write;
    logic [ADDR_W-1:0] commit_addr;
    logic [63:0]       commit_wdata;

    // Commit path: in IDLE only the direct (single-edge) case can commit, and
    // it uses the request as presented; otherwise the latched copy is used so
    // that addr/wdata changes after sampling have no effect.
    always_comb begin
        start        = (state_reg == IDLE) && (re || we);
        commit       = (DIRECT && start) || ((state_reg == BUSY) && (cnt_reg == 4'd0));
        commit_addr  = (state_reg == IDLE) ? addr  : addr_reg;
        commit_wdata = (state_reg == IDLE) ? wdata : wdata_reg;
        commit_write = (state_reg == IDLE) ? we    : write_reg;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (re || we) begin
                    cnt_next   = CNT_LOAD;
                    state_next = DIRECT ? DONE : BUSY;
                end
            end
            BUSY: begin
                // Counter is loaded with LATENCY-1, so expiry at zero lands
                // on the LATENCY-th edge after sampling.
                if (cnt_reg == 4'd0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State and request registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            addr_reg  <= '0;
            wdata_reg <= 64'h0;
            write_reg <= 1'b0;
            rd_data   <= 64'h0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (start) begin
                addr_reg  <= addr;
                wdata_reg <= wdata;
                write_reg <= we;
            end
            if (commit && !commit_write) begin
                rd_data <= mem[commit_addr];
            end
        end
    end

    // Array write; gated by rst_n so an aborted write never lands.
    always_ff @(posedge clk) begin
        if (rst_n && commit && commit_write) begin
            mem[commit_addr] <= commit_wdata;
        end
    end

    // Moore outputs
    always_comb begin
        rdy  = (state_reg == DONE);
        busy = (state_reg != IDLE);
    end

endmodule

// File: tb/tb_line_mem_responder.sv
module tb_line_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [13:0] addr_a, addr_b;
    logic        re_a, we_a, re_b, we_b;
    logic [63:0] wdata_a, wdata_b, rd_data_a, rd_data_b;
    logic        rdy_a, busy_a, rdy_b, busy_b;

    int vectors     = 0;
    int miscompares = 0;

    // Instance under test for the default latency and a single-edge variant.
    line_mem_responder #(.ADDR_W(14), .LATENCY(4), .INIT_FILE("")) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr_a), .re(re_a), .we(we_a),
        .wdata(wdata_a), .rd_data(rd_data_a), .rdy(rdy_a), .busy(busy_a)
    );

    line_mem_responder #(.ADDR_W(14), .LATENCY(1), .INIT_FILE("")) dut1 (
        .clk(clk), .rst_n(rst_n), .addr(addr_b), .re(re_b), .we(we_b),
        .wdata(wdata_b), .rd_data(rd_data_b), .rdy(rdy_b), .busy(busy_b)
    );

    bit          sel_b = 1'b0;
    logic        obs_rdy, obs_busy;
    logic [63:0] obs_rd_data;
    assign obs_rdy     = sel_b ? rdy_b     : rdy_a;
    assign obs_busy    = sel_b ? busy_b    : busy_a;
    assign obs_rd_data = sel_b ? rd_data_b : rd_data_a;

    localparam logic [63:0] D_WR  = 64'h4444_3333_2222_1111;
    localparam logic [63:0] D_H   = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] D_DB  = 64'hDEAD_BEEF_0000_FFFF;
    localparam logic [63:0] D_L1  = 64'hA5A5_5A5A_F00D_CAFE;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request: present for the sampling edge, then withdraw and swap
    // wdata to d_after. Returns edges from sampling edge to rdy visibility,
    // the read line and busy in the rdy cycle, and rdy/busy one cycle later.
    task automatic do_op(input bit b, input logic w, input logic r,
                         input logic [13:0] a, input logic [63:0] d,
                         input logic [63:0] d_after,
                         output int edges, output logic [63:0] data,
                         output logic busy_at_rdy, output logic rdy_after,
                         output logic busy_after);
        sel_b = b;
        if (b) begin we_b = w; re_b = r; addr_b = a; wdata_b = d; end
        else   begin we_a = w; re_a = r; addr_a = a; wdata_a = d; end
        step();
        if (b) begin we_b = 1'b0; re_b = 1'b0; wdata_b = d_after; end
        else   begin we_a = 1'b0; re_a = 1'b0; wdata_a = d_after; end
        edges = 0;
        while (obs_rdy !== 1'b1 && edges < 20) begin
            step();
            edges++;
        end
        data        = obs_rd_data;
        busy_at_rdy = obs_busy;
        step();
        rdy_after   = obs_rdy;
        busy_after  = obs_busy;
        $display("op dut%0d we=%0b re=%0b addr=%h edges=%0d rd_data=%h",
                 b ? 1 : 4, w, r, a, edges, data);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        re_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
        re_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
        step(); step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            vectors++;
            if ({rdy_a, busy_a, rd_data_a} !== {2'b00, 64'h0}) begin
                miscompares++;
                $display("FAIL reset_idle cycle %0d: rdy=%b busy=%b rd_data=%h, expected 0 0 0",
                         i, rdy_a, busy_a, rd_data_a);
            end
            vectors++;
            if ({rdy_b, busy_b, rd_data_b} !== {2'b00, 64'h0}) begin
                miscompares++;
                $display("FAIL reset_idle_l1 cycle %0d: rdy=%b busy=%b rd_data=%h, expected 0 0 0",
                         i, rdy_b, busy_b, rd_data_b);
            end
        end
    endtask

    task automatic test_write_read();
        int edges; logic [63:0] data; logic bz, ra, ba;
        do_op(1'b0, 1'b1, 1'b0, 14'h0012, D_WR, D_WR, edges, data, bz, ra, ba);
        vectors++;
        if (edges !== 4) begin
            miscompares++;
            $display("FAIL write_latency: edges=%0d, expected 4", edges);
        end
        vectors++;
        if ({bz, ra, ba} !== 3'b100) begin
            miscompares++;
            $display("FAIL write_rdy_pulse: busy@rdy,rdy+1,busy+1=%b, expected 100", {bz, ra, ba});
        end
        do_op(1'b0, 1'b0, 1'b1, 14'h0012, 64'h0, 64'h0, edges, data, bz, ra, ba);
        vectors++;
        if (edges !== 4) begin
            miscompares++;
            $display("FAIL read_latency: edges=%0d, expected 4", edges);
        end
        vectors++;
        if (data !== D_WR) begin
            miscompares++;
            $display("FAIL read_data: got %h, expected %h", data, D_WR);
        end
    endtask

    task automatic test_held_re();
        int edges; logic [63:0] data; logic bz, ra, ba;
        logic exp_rdy, exp_busy;
        do_op(1'b0, 1'b1, 1'b0, 14'h0003, D_H, D_H, edges, data, bz, ra, ba);
        sel_b  = 1'b0;
        re_a   = 1'b1;
        addr_a = 14'h0003;
        step();
        // k counts edges after the first sampling edge; period is 6.
        for (int k = 0; k < 18; k++) begin
            exp_rdy  = ((k % 6) == 4);
            exp_busy = ((k % 6) != 5);
            vectors++;
            if ({rdy_a, busy_a} !== {exp_rdy, exp_busy}) begin
                miscompares++;
                $display("FAIL held_re k=%0d: rdy=%b busy=%b, expected %b %b",
                         k, rdy_a, busy_a, exp_rdy, exp_busy);
            end
            if (exp_rdy) begin
                vectors++;
                if (rd_data_a !== D_H) begin
                    miscompares++;
                    $display("FAIL held_re_data k=%0d: got %h, expected %h", k, rd_data_a, D_H);
                end
                $display("held re completion k=%0d rd_data=%h", k, rd_data_a);
            end
            if (k < 17) step();
        end
        re_a = 1'b0;
    endtask

    task automatic test_simultaneous();
        int edges; logic [63:0] data; logic bz, ra, ba;
        do_op(1'b0, 1'b1, 1'b1, 14'h0020, D_DB, D_DB, edges, data, bz, ra, ba);
        vectors++;
        if (edges !== 4 || data !== D_H) begin
            miscompares++;
            $display("FAIL rewe_rd_data_hold: edges=%0d rd_data=%h, expected 4 %h", edges, data, D_H);
        end
        do_op(1'b0, 1'b0, 1'b1, 14'h0020, 64'h0, 64'h0, edges, data, bz, ra, ba);
        vectors++;
        if (data !== D_DB) begin
            miscompares++;
            $display("FAIL rewe_write_won: got %h, expected %h", data, D_DB);
        end
    endtask

    task automatic test_input_change_and_abort();
        int edges; logic [63:0] data; logic bz, ra, ba;
        int rdy_seen;
        do_op(1'b0, 1'b1, 1'b0, 14'h0005, 64'h1, 64'h0, edges, data, bz, ra, ba);
        do_op(1'b0, 1'b0, 1'b1, 14'h0005, 64'h0, 64'h0, edges, data, bz, ra, ba);
        vectors++;
        if (data !== 64'h1) begin
            miscompares++;
            $display("FAIL wdata_change_inflight: got %h, expected %h", data, 64'h1);
        end
        // Abort a write to the same line partway through BUSY.
        sel_b = 1'b0;
        we_a = 1'b1; addr_a = 14'h0005; wdata_a = 64'h2;
        step();
        we_a = 1'b0;
        step(); step();
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({rdy_a, busy_a, rd_data_a} !== {2'b00, 64'h0}) begin
            miscompares++;
            $display("FAIL async_reset: rdy=%b busy=%b rd_data=%h, expected 0 0 0",
                     rdy_a, busy_a, rd_data_a);
        end
        #1;
        rst_n = 1'b1;
        rdy_seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (rdy_a !== 1'b0) rdy_seen++;
        end
        vectors++;
        if (rdy_seen !== 0) begin
            miscompares++;
            $display("FAIL abort_no_rdy: rdy cycles=%0d, expected 0", rdy_seen);
        end
        $display("abort write addr=0005 rdy cycles after reset=%0d", rdy_seen);
        do_op(1'b0, 1'b0, 1'b1, 14'h0005, 64'h0, 64'h0, edges, data, bz, ra, ba);
        vectors++;
        if (edges !== 4 || data !== 64'h1) begin
            miscompares++;
            $display("FAIL abort_write_discarded: edges=%0d rd_data=%h, expected 4 %h",
                     edges, data, 64'h1);
        end
    endtask

    task automatic test_latency1();
        int edges; logic [63:0] data; logic bz, ra, ba;
        do_op(1'b1, 1'b1, 1'b0, 14'h3FFF, D_L1, D_L1, edges, data, bz, ra, ba);
        vectors++;
        if (edges !== 0 || {bz, ra, ba} !== 3'b100) begin
            miscompares++;
            $display("FAIL l1_write_timing: edges=%0d pulse=%b, expected 0 100", edges, {bz, ra, ba});
        end
        do_op(1'b1, 1'b0, 1'b1, 14'h3FFF, 64'h0, 64'h0, edges, data, bz, ra, ba);
        vectors++;
        if (edges !== 0 || {bz, ra, ba} !== 3'b100) begin
            miscompares++;
            $display("FAIL l1_read_timing: edges=%0d pulse=%b, expected 0 100", edges, {bz, ra, ba});
        end
        vectors++;
        if (data !== D_L1) begin
            miscompares++;
            $display("FAIL l1_read_data: got %h, expected %h", data, D_L1);
        end
        sel_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_held_re();
        test_simultaneous();
        test_input_change_and_abort();
        test_latency1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
